// File: rtl/vga_sync_gen_if.sv
// ----------------------------------------------------------------------------
// vga_sync_gen_if
//   Bundle of raster timing signals produced by vga_sync_gen and consumed by
//   the object/shape generators and the video output stage.
//
//   Signals
//     HCount       10  current pixel column
//     VCount       10  current line
//     hsync        1   horizontal sync, active low
//     vsync        1   vertical sync, active low
//     video_on     1   high inside the visible area
//     pixel_tick   1   one-clk pulse per pixel period
//     frame_start  1   one-clk pulse when the counts wrap to (0,0)
//
//   Modports
//     master  timing generator (drives everything)
//     slave   pixel pipeline (observes everything)
// ----------------------------------------------------------------------------
interface vga_sync_gen_if;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pixel_tick;
  logic       frame_start;

  modport master (
    output HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );

  modport slave (
    input HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator. Divides the system clock down to a pixel rate,
//   walks HCount/VCount across the full raster (visible area plus porches and
//   sync), and produces hsync/vsync/video_on plus pixel_tick and frame_start
//   strobes. Defaults give 640x480@60 Hz from a 50 MHz clock.
//
//   Ports
//     clk    in   system clock, all state on its rising edge
//     reset  in   synchronous, active-high; aborts any frame in progress
//     vga    master modport of vga_sync_gen_if carrying all timing outputs
// ----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // The counters are 10 bits wide, so a raster that does not fit is rejected
  // at elaboration rather than silently aliasing.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be >= 1");
    end
  endgenerate

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             advance;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             wrap_frame;

  // Next-state counts. Everything registered below is derived from these so
  // that the sync/blanking decodes land in the same clk as the counts.
  always_comb begin
    advance    = (div == DIV_LAST);
    h_next     = vga.HCount;
    v_next     = vga.VCount;
    wrap_frame = 1'b0;
    if (advance) begin
      if (vga.HCount == H_LAST) begin
        h_next = 10'd0;
        if (vga.VCount == V_LAST) begin
          v_next     = 10'd0;
          wrap_frame = 1'b1;
        end else begin
          v_next = vga.VCount + 10'd1;
        end
      end else begin
        h_next = vga.HCount + 10'd1;
      end
    end
  end

  // Divider, counters and registered decodes. vsync only looks at the line
  // count, so it spans whole lines regardless of the horizontal position.
  always_ff @(posedge clk) begin
    if (reset) begin
      div             <= '0;
      vga.HCount      <= 10'd0;
      vga.VCount      <= 10'd0;
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.video_on    <= 1'b0;
      vga.pixel_tick  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      div             <= advance ? '0 : div + 1'b1;
      vga.HCount      <= h_next;
      vga.VCount      <= v_next;
      vga.hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
      vga.vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
      vga.video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
      vga.pixel_tick  <= advance;
      vga.frame_start <= wrap_frame;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Exercises two generators off one clock: dut_a with the default 640x480
//   timing for horizontal behaviour, and dut_b with a tiny raster and a /3
//   divider so vertical timing and whole frames fit in a short run.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       fs;
  } obs_t;

  typedef struct {
    int   n;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();

  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (if_a)
  );

  vga_sync_gen #(
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (2),
    .V_DISPLAY (6),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3),
    .CLK_DIV   (3)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (if_b)
  );

  // Clock edges seen since the last edge that sampled reset high.
  int n_a = 0;
  int n_b = 0;

  always @(posedge clk) begin
    n_a <= rst_a ? 0 : n_a + 1;
    n_b <= rst_b ? 0 : n_b + 1;
  end

  int checks = 0;
  int passed = 0;

  function automatic obs_t mk(int h, int v, bit hs, bit vs, bit vo, bit pt, bit fs);
    obs_t o;
    o.h  = h[9:0];
    o.v  = v[9:0];
    o.hs = hs;
    o.vs = vs;
    o.vo = vo;
    o.pt = pt;
    o.fs = fs;
    return o;
  endfunction

  function automatic vec_t vec(int n, obs_t e);
    vec_t r;
    r.n   = n;
    r.exp = e;
    return r;
  endfunction

  // Reference: the pixel index is simply elapsed clks / divider, and the
  // raster position follows from div/mod by the line and frame lengths.
  function automatic obs_t model(int n, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb, int dv);
    int ht, vt, p, h, v;
    bit tick;
    if (n == 0) return mk(0, 0, 1, 1, 0, 0, 0);
    ht   = hd + hf + hsw + hb;
    vt   = vd + vf + vsw + vb;
    p    = n / dv;
    h    = p % ht;
    v    = (p / ht) % vt;
    tick = (n % dv) == 0;
    return mk(h, v,
              !(h >= hd + hf && h < hd + hf + hsw),
              !(v >= vd + vf && v < vd + vf + vsw),
              (h < hd) && (v < vd),
              tick,
              tick && ((p % (ht * vt)) == 0));
  endfunction

  function automatic obs_t model_a(int n);
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2);
  endfunction

  function automatic obs_t model_b(int n);
    return model(n, 8, 2, 3, 2, 6, 2, 2, 3, 3);
  endfunction

  function automatic obs_t obs_a();
    return mk(int'(if_a.HCount), int'(if_a.VCount), if_a.hsync, if_a.vsync,
              if_a.video_on, if_a.pixel_tick, if_a.frame_start);
  endfunction

  function automatic obs_t obs_b();
    return mk(int'(if_b.HCount), int'(if_b.VCount), if_b.hsync, if_b.vsync,
              if_b.video_on, if_b.pixel_tick, if_b.frame_start);
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b",
               name, act.h, act.v, act.hs, act.vs, act.vo, act.pt, act.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.pt, exp.fs);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive resets, then return at the next falling
  // edge, where outputs are sampled well away from the rising edge.
  task automatic applyStimulus(input logic ra, input logic rb);
    rst_a = ra;
    rst_b = rb;
    @(negedge clk);
  endtask

  task automatic run_a_to(input int target);
    int guard;
    guard = 0;
    while (n_a < target && guard < 10000) begin
      applyStimulus(1'b0, rst_b);
      checkOutput("model_a", obs_a(), model_a(n_a));
      guard++;
    end
    checkCount("reach_a", n_a, target);
  endtask

  task automatic run_b_to(input int target);
    int guard;
    guard = 0;
    while (n_b < target && guard < 10000) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("model_b", obs_b(), model_b(n_b));
      guard++;
    end
    checkCount("reach_b", n_b, target);
  endtask

  task automatic wait_frame_b(output int cnt);
    cnt = 0;
    do begin
      applyStimulus(1'b0, 1'b0);
      cnt++;
    end while (!if_b.frame_start && cnt < 2000);
  endtask

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  initial begin
    obs_t rst_val;
    int   cnt;
    int   hold_a;
    int   hold_b;
    logic ra;
    logic rb;

    rst_val = mk(0, 0, 1, 1, 0, 0, 0);

    // Default timing: columns around the visible edge and the hsync window.
    tbl_a.push_back(vec(1,    mk(0,   0, 1, 1, 1, 0, 0)));
    tbl_a.push_back(vec(2,    mk(1,   0, 1, 1, 1, 1, 0)));
    tbl_a.push_back(vec(1278, mk(639, 0, 1, 1, 1, 1, 0)));
    tbl_a.push_back(vec(1280, mk(640, 0, 1, 1, 0, 1, 0)));
    tbl_a.push_back(vec(1310, mk(655, 0, 1, 1, 0, 1, 0)));
    tbl_a.push_back(vec(1311, mk(655, 0, 1, 1, 0, 0, 0)));
    tbl_a.push_back(vec(1312, mk(656, 0, 0, 1, 0, 1, 0)));
    tbl_a.push_back(vec(1502, mk(751, 0, 0, 1, 0, 1, 0)));
    tbl_a.push_back(vec(1504, mk(752, 0, 1, 1, 0, 1, 0)));
    tbl_a.push_back(vec(1598, mk(799, 0, 1, 1, 0, 1, 0)));
    tbl_a.push_back(vec(1599, mk(799, 0, 1, 1, 0, 0, 0)));
    tbl_a.push_back(vec(1600, mk(0,   1, 1, 1, 1, 1, 0)));
    tbl_a.push_back(vec(3200, mk(0,   2, 1, 1, 1, 1, 0)));

    // Small raster (15x13 pixels, /3): vertical edges, vsync lines, frame wrap.
    tbl_b.push_back(vec(1,   mk(0,  0,  1, 1, 1, 0, 0)));
    tbl_b.push_back(vec(3,   mk(1,  0,  1, 1, 1, 1, 0)));
    tbl_b.push_back(vec(24,  mk(8,  0,  1, 1, 0, 1, 0)));
    tbl_b.push_back(vec(30,  mk(10, 0,  0, 1, 0, 1, 0)));
    tbl_b.push_back(vec(36,  mk(12, 0,  0, 1, 0, 1, 0)));
    tbl_b.push_back(vec(39,  mk(13, 0,  1, 1, 0, 1, 0)));
    tbl_b.push_back(vec(42,  mk(14, 0,  1, 1, 0, 1, 0)));
    tbl_b.push_back(vec(45,  mk(0,  1,  1, 1, 1, 1, 0)));
    tbl_b.push_back(vec(225, mk(0,  5,  1, 1, 1, 1, 0)));
    tbl_b.push_back(vec(270, mk(0,  6,  1, 1, 0, 1, 0)));
    tbl_b.push_back(vec(315, mk(0,  7,  1, 1, 0, 1, 0)));
    tbl_b.push_back(vec(360, mk(0,  8,  1, 0, 0, 1, 0)));
    tbl_b.push_back(vec(372, mk(4,  8,  1, 0, 0, 1, 0)));
    tbl_b.push_back(vec(402, mk(14, 8,  1, 0, 0, 1, 0)));
    tbl_b.push_back(vec(405, mk(0,  9,  1, 0, 0, 1, 0)));
    tbl_b.push_back(vec(450, mk(0,  10, 1, 1, 0, 1, 0)));
    tbl_b.push_back(vec(582, mk(14, 12, 1, 1, 0, 1, 0)));
    tbl_b.push_back(vec(584, mk(14, 12, 1, 1, 0, 0, 0)));
    tbl_b.push_back(vec(585, mk(0,  0,  1, 1, 1, 1, 1)));
    tbl_b.push_back(vec(586, mk(0,  0,  1, 1, 1, 0, 0)));
    tbl_b.push_back(vec(588, mk(1,  0,  1, 1, 1, 1, 0)));

    @(negedge clk);

    // Reset held for several clks, then the first clk after release.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("reset_hold_a", obs_a(), rst_val);
      checkOutput("reset_hold_b", obs_b(), rst_val);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("release_a", obs_a(), mk(0, 0, 1, 1, 1, 0, 0));

    for (int i = 0; i < tbl_a.size(); i++) begin
      run_a_to(tbl_a[i].n);
      checkOutput($sformatf("vec_a[%0d]", i), obs_a(), tbl_a[i].exp);
    end

    for (int i = 0; i < tbl_b.size(); i++) begin
      run_b_to(tbl_b[i].n);
      checkOutput($sformatf("vec_b[%0d]", i), obs_b(), tbl_b[i].exp);
    end

    // Frame period on the small raster: 195 pixels * 3 clks.
    wait_frame_b(cnt);
    checkCount("frame_gap_first", cnt, 582);
    checkOutput("frame_pulse_1", obs_b(), mk(0, 0, 1, 1, 1, 1, 1));
    wait_frame_b(cnt);
    checkCount("frame_period", cnt, 585);
    checkOutput("frame_pulse_2", obs_b(), mk(0, 0, 1, 1, 1, 1, 1));

    // Single-clk reset in the middle of a line aborts the frame.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    run_b_to(195);
    checkOutput("midline_pos", obs_b(), mk(5, 4, 1, 1, 1, 1, 0));
    applyStimulus(1'b0, 1'b1);
    checkOutput("midline_reset", obs_b(), rst_val);
    applyStimulus(1'b0, 1'b0);
    checkOutput("midline_restart", obs_b(), mk(0, 0, 1, 1, 1, 0, 0));
    wait_frame_b(cnt);
    checkCount("restart_to_frame", cnt, 584);

    // Random reset pulses on both generators, every clk checked.
    hold_a = 0;
    hold_b = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_a == 0 && $urandom_range(0, 299) == 0) hold_a = $urandom_range(1, 3);
      if (hold_b == 0 && $urandom_range(0, 149) == 0) hold_b = $urandom_range(1, 3);
      ra = (hold_a > 0);
      rb = (hold_b > 0);
      if (hold_a > 0) hold_a--;
      if (hold_b > 0) hold_b--;
      applyStimulus(ra, rb);
      checkOutput("rand_a", obs_a(), model_a(n_a));
      checkOutput("rand_b", obs_b(), model_b(n_b));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
